mem_bus_responder: RTL
======================

# mem_bus_responder

Byte-wide responder on the memory bus driven by `Memory_controller`. It is the RAM/IO side of the `mem_wr`/`mem_a`/`mem_dout`/`mem_din` interface: a synchronous-read RAM plus a memory-mapped output port. The output port's bytes pass through a small TX FIFO whose fullness drives `io_buffer_full` back to the controller. It sits at the top level between the CPU core and the RAM/UART host side, and it doubles as the simulation memory model.

## Interface
- ADDR_WIDTH, 17, RAM byte-address width (RAM is 2^ADDR_WIDTH bytes)
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2
- DRAIN_DIV, 4, minimum cycles between TX pops; at least 1
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-high reset
- rdy_in  in  1  global ready; while low, no RAM/FIFO writes and `mem_din` is held
- mem_wr  in  1  1 = write cycle, 0 = read cycle
- mem_a  in  32  byte address
- mem_dout  in  8  write data from controller
- mem_din  out  8  read data to controller, registered
- io_buffer_full  out  1  TX FIFO holds FIFO_DEPTH entries
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  head byte valid for the host
- tx_ready  in  1  host accepts byte
- sim_halt  out  1  sticky; set by a write to the halt register
- rx_data  in  8  input byte (IO_IN_EN only)
- rx_valid  in  1  input byte available (IO_IN_EN only)
- rx_pop  out  1  one-cycle consume strobe (IO_IN_EN only)

## Operation
- Decode:
  - `mem_a[17:16] == 2'b11` selects IO.
  - Otherwise RAM is selected, indexed by `mem_a[ADDR_WIDTH-1:0]`; upper bits are ignored.
- IO registers:
  - IO_DATA at 0x30000.
  - IO_STAT at 0x30004.
  - Other IO offsets: reads return 0, writes are ignored.
- RAM write (`rdy_in && mem_wr`): store `mem_dout` at the edge. `mem_din` holds its previous value.
- RAM read (`rdy_in && !mem_wr`): `mem_din <= ram[addr]`.
- IO write to IO_DATA:
  - Pushes `mem_dout` into the TX FIFO.
  - If the FIFO is full, the byte is dropped. The controller already gates `mem_wr` with `io_buffer_full`, so this case is a protocol violation.
- IO write to IO_STAT: sets `sim_halt` (sticky until reset).
- IO read of IO_STAT: `mem_din <= {4'b0, count[3:0]}`, where `count` is the FIFO occupancy.
- IO read of IO_DATA: see Configuration.
- TX FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - `count` has width log2(FIFO_DEPTH)+1.
  - `tx_data` is the head entry.
  - Pop on `tx_valid && tx_ready`.
  - Push and pop in the same cycle leave `count` unchanged. This is allowed even when the FIFO is full; the pop makes room for the push.
- Drain pacing:
  - `pace` counter is loaded with DRAIN_DIV-1 on each pop and decrements to 0.
  - `tx_valid = (count != 0) && (pace == 0)`.
  - The drain runs independently of `rdy_in`.
- `io_buffer_full = (count == FIFO_DEPTH)`, decoded combinationally from registers.
- RAM contents are not reset. The bench preloads RAM with `$readmemh`.

## Timing
- Reset values:
  - `mem_din`, `tx_data`: 0
  - `tx_valid`, `io_buffer_full`, `sim_halt`, `rx_pop`: 0
  - `count`, `pace`, pointers: 0
- Read latency is 1 cycle: address at edge N produces data on `mem_din` after edge N+1's update, in step with the controller consuming `mem_din` one cycle after issuing `mem_a`.
- Read-after-write to the same RAM address on the next cycle returns the new byte.
- `io_buffer_full` rises the cycle after the push that fills the FIFO. It falls the cycle after the pop that frees an entry.
- `rdy_in` low: the write is suppressed and `mem_din` is held; FIFO pop and `pace` continue.
- Reset asserted mid-drain: FIFO is emptied immediately and `tx_valid` drops asynchronously.

## Configuration
- `IO_IN_EN` defined:
  - A read of IO_DATA returns `rx_valid ? rx_data : 8'h00`.
  - `rx_pop` pulses for one cycle when `rx_valid` is high.
- `IO_IN_EN` undefined:
  - The `rx_*` ports are absent.
  - A read of IO_DATA returns 0.

## Structure
- `Const.v` gains:
  - `IO_BASE` (32'h30000)
  - `IO_DATA_OFS` (0)
  - `IO_STAT_OFS` (4)
  - `IO_SEL_BITS` (2'b11 on bits 17:16)
- Sub-module `io_tx_fifo`:
  - Parameterized FIFO_DEPTH.
  - Ports: push/`push_data`, pop, `head`, `count`, `full`, `empty`.
  - Owns all pointer logic.
- RAM array, address decode and `pace` counter live in the top module.

## Test plan
- Write 0xA5 to 0x00010, then read 0x00010 on the next cycle -> `mem_din == 8'hA5` one cycle after the read address.
- Four reads at 0x1000..0x1003 preloaded 11,22,33,44 -> `mem_din` is 11,22,33,44 on the four cycles following each address.
- Nine IO_DATA writes with `tx_ready=0`, FIFO_DEPTH=8 -> `io_buffer_full` high after the 8th write. The 9th is dropped; the controller never asserts `mem_wr` then.
- `tx_ready=1` held, FIFO holding 3 bytes, DRAIN_DIV=4 -> pops on cycles 0,4,8. `io_buffer_full` falls the cycle after the first pop from full.
- Write IO_STAT -> `sim_halt` is 1 next cycle and stays 1. A read of IO_STAT with 2 entries queued returns 8'h02.
- Assert `rst_in` mid-drain with 5 bytes queued -> `tx_valid` and `count` are 0 immediately. A RAM read after reset returns the preloaded data.

Source files
------------

// File: rtl/mem_bus_responder_pkg.sv
// Shared constants and address decode for the memory bus responder.
package mem_bus_responder_pkg;

  localparam logic [31:0] IO_BASE     = 32'h0003_0000;
  localparam logic [31:0] IO_DATA_OFS = 32'd0;
  localparam logic [31:0] IO_STAT_OFS = 32'd4;
  localparam logic [1:0]  IO_SEL_BITS = 2'b11;

  localparam logic [31:0] IO_DATA_ADDR = IO_BASE + IO_DATA_OFS;
  localparam logic [31:0] IO_STAT_ADDR = IO_BASE + IO_STAT_OFS;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_IO_DATA,
    SEL_IO_STAT,
    SEL_IO_NONE
  } io_sel_e;

  // Bits above 17 never take part in the decode.
  function automatic io_sel_e decode_sel(input logic [31:0] a);
    if (a[17:16] != IO_SEL_BITS)        return SEL_RAM;
    if (a[17:0] == IO_DATA_ADDR[17:0])  return SEL_IO_DATA;
    if (a[17:0] == IO_STAT_ADDR[17:0])  return SEL_IO_STAT;
    return SEL_IO_NONE;
  endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Memory bus plus TX/RX byte streams between controller/host and the responder.
// The rx_* signals exist only when IO_IN_EN is defined.
interface mem_bus_responder_if;
  logic        mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
`ifdef IO_IN_EN
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;

  modport slave  (input  mem_wr, mem_a, mem_dout, tx_ready, rx_data, rx_valid,
                  output mem_din, io_buffer_full, tx_data, tx_valid, rx_pop);
  modport master (output mem_wr, mem_a, mem_dout, tx_ready, rx_data, rx_valid,
                  input  mem_din, io_buffer_full, tx_data, tx_valid, rx_pop);
`else
  modport slave  (input  mem_wr, mem_a, mem_dout, tx_ready,
                  output mem_din, io_buffer_full, tx_data, tx_valid);
  modport master (output mem_wr, mem_a, mem_dout, tx_ready,
                  input  mem_din, io_buffer_full, tx_data, tx_valid);
`endif
endinterface

// File: rtl/mem_bus_responder_io_tx_fifo.sv
// Circular TX byte FIFO; a pop frees room for a same-cycle push even when full.
module io_tx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        push_i,
  input  logic [7:0]                  push_data_i,
  input  logic                        pop_i,
  output logic [7:0]                  head_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        full_o,
  output logic                        empty_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign count_o = count_q;
  // Storage is not reset, so mask the head while empty.
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/mem_bus_responder.sv
// RAM + memory-mapped IO responder with a paced TX FIFO.
// Define IO_IN_EN to enable the rx byte input on IO_DATA reads.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8,
  parameter int DRAIN_DIV  = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  mem_bus_responder_if.slave  bus,
  output logic                sim_halt
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PACE_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'(DRAIN_DIV - 1);

  logic [7:0]            ram_q [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ram_addr;
  io_sel_e               sel;
  logic                  ram_we, push, pop, tx_valid, fifo_full, fifo_empty;
  logic [7:0]            fifo_head, io_in_byte;
  logic [CNT_W-1:0]      fifo_count;
  logic [3:0]            cnt4;
  logic [7:0]            mem_din_q, mem_din_d;
  logic                  halt_q, halt_d;
  logic [PACE_W-1:0]     pace_q, pace_d;
  logic                  unused_addr;

  assign sel         = decode_sel(bus.mem_a);
  assign ram_addr    = bus.mem_a[ADDR_WIDTH-1:0];
  assign unused_addr = ^bus.mem_a;
  assign cnt4        = 4'(fifo_count);

  assign ram_we = rdy_in && bus.mem_wr && (sel == SEL_RAM);
  assign push   = rdy_in && bus.mem_wr && (sel == SEL_IO_DATA);
  assign halt_d = halt_q || (rdy_in && bus.mem_wr && (sel == SEL_IO_STAT));

  // Drain pacing ignores rdy_in.
  assign tx_valid = !fifo_empty && (pace_q == '0);
  assign pop      = tx_valid && bus.tx_ready;

`ifdef IO_IN_EN
  logic rx_pop_q;
  assign io_in_byte = bus.rx_valid ? bus.rx_data : 8'h00;
  assign bus.rx_pop = rx_pop_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) rx_pop_q <= 1'b0;
    else        rx_pop_q <= rdy_in && !bus.mem_wr && (sel == SEL_IO_DATA) && bus.rx_valid;
  end
`else
  assign io_in_byte = 8'h00;
`endif

  always_comb begin
    mem_din_d = mem_din_q;
    if (rdy_in && !bus.mem_wr) begin
      case (sel)
        SEL_RAM:     mem_din_d = ram_q[ram_addr];
        SEL_IO_DATA: mem_din_d = io_in_byte;
        SEL_IO_STAT: mem_din_d = {4'b0000, cnt4};
        default:     mem_din_d = 8'h00;
      endcase
    end
  end

  always_comb begin
    pace_d = pace_q;
    if (pop)              pace_d = PACE_LOAD;
    else if (pace_q != '0) pace_d = pace_q - PACE_W'(1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_din_q <= 8'h00;
      halt_q    <= 1'b0;
      pace_q    <= '0;
    end else begin
      mem_din_q <= mem_din_d;
      halt_q    <= halt_d;
      pace_q    <= pace_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram_q[ram_addr] <= bus.mem_dout;
  end

  io_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .push_i      (push),
    .push_data_i (bus.mem_dout),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.mem_din        = mem_din_q;
  assign bus.io_buffer_full = fifo_full;
  assign bus.tx_data        = fifo_head;
  assign bus.tx_valid       = tx_valid;
  assign sim_halt           = halt_q;
endmodule
